// File: rtl/mdu_seq_pkg.sv
// +----------------------------------------------------------------------+
// | mdu_seq_pkg : op/state encodings shared by the MDU sequencer. rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

package mdu_seq_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MUL  = 2'd1;
  localparam state_t S_DIV  = 2'd2;
  localparam state_t S_DONE = 2'd3;

  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = 5;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_seq_div_step_core.sv
// +----------------------------------------------------------------------+
// | div_step_core : one restoring-divide iteration on {rem,quo}. rev 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module div_step_core
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // rem_in < divisor always holds, so diff[WIDTH] is a clean borrow flag
  always_comb begin
    trial = {rem_in, quo_in[WIDTH-1]};
    diff  = trial - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = trial[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// +----------------------------------------------------------------------+
// | mdu_seq : HI/LO multiply/divide sequencer with pipeline stall. rev 1.0|
// +----------------------------------------------------------------------+
`default_nettype none

module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancel,
  output logic             stallE,
  output logic             busy,
  output logic             hiwrite,
  output logic             lowrite,
  output logic [WIDTH-1:0] hiresult,
  output logic [WIDTH-1:0] loresult
);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_STEPS - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic                 start;
  logic                 div_zero;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   a_ext, b_ext;
  logic [WIDTH-1:0]     step_rem, step_quo;
  logic [WIDTH-1:0]     fix_rem, fix_quo;

  assign start    = startE & ~cancel;
  assign div_zero = op_is_div(opE) & (srcbE == '0);
  assign a_neg    = op_is_signed(opE) & srcaE[WIDTH-1];
  assign b_neg    = op_is_signed(opE) & srcbE[WIDTH-1];
  assign a_mag    = a_neg ? -srcaE : srcaE;
  assign b_mag    = b_neg ? -srcbE : srcbE;
  // Sign extension to 2*WIDTH makes one modular multiply serve MULT and MULTU
  assign a_ext    = {{WIDTH{a_neg}}, srcaE};
  assign b_ext    = {{WIDTH{b_neg}}, srcbE};

  div_step_core #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  assign fix_quo = qneg_q ? -step_quo : step_quo;
  assign fix_rem = rneg_q ? -step_rem : step_rem;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!op_is_div(opE)) state_d = S_MUL;
          else if (div_zero)   state_d = S_DONE;
          else                 state_d = S_DIV;
        end
      end
      S_MUL:   if (cnt_q == MUL_LAST) state_d = S_DONE;
      S_DIV:   if (cnt_q == DIV_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cancel) state_d = S_IDLE;
  end

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    prod_d = prod_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d  = '0;
          prod_d = a_ext * b_ext;
          rem_d  = '0;
          quo_d  = a_mag;
          dvs_d  = b_mag;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (div_zero) begin
            hi_d = srcaE;
            lo_d = '1;
          end
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MUL_LAST) begin
          cnt_d = '0;
          hi_d  = prod_q[2*WIDTH-1:WIDTH];
          lo_d  = prod_q[WIDTH-1:0];
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          hi_d  = fix_rem;
          lo_d  = fix_quo;
        end
      end
      default: ;
    endcase
    if (cancel) cnt_d = '0;
  end

  always_comb begin
    stallE  = ~cancel & (((state_q == S_IDLE) & startE) |
                         (state_q == S_MUL) | (state_q == S_DIV));
    busy    = (state_q != S_IDLE);
    hiwrite = (state_q == S_DONE) & ~cancel;
    lowrite = (state_q == S_DONE) & ~cancel;
  end

  assign hiresult = hi_q;
  assign loresult = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// +----------------------------------------------------------------------+
// | tb_mdu_seq : directed + random self-check of mdu_seq. rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mdu_seq;

  localparam int MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        cancel;
  logic        stallE;
  logic        busy;
  logic        hiwrite;
  logic        lowrite;
  logic [31:0] hiresult;
  logic [31:0] loresult;

  int total = 0;
  int bad   = 0;

  mdu_seq #(
    .WIDTH      (32),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .startE   (startE),
    .opE      (opE),
    .srcaE    (srcaE),
    .srcbE    (srcbE),
    .cancel   (cancel),
    .stallE   (stallE),
    .busy     (busy),
    .hiwrite  (hiwrite),
    .lowrite  (lowrite),
    .hiresult (hiresult),
    .loresult (loresult)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic, SV '/' and '%' truncate toward zero
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; lat = MUL_CYCLES + 1; end
      2'b01: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; lat = MUL_CYCLES + 1; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; lat = 1;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb;
          hi = r[31:0]; lo = q[31:0]; lat = 33;
        end else begin
          uq = ua / ub; ur = ua % ub;
          hi = ur[31:0]; lo = uq[31:0]; lat = 33;
        end
      end
    endcase
  endfunction

  // Holds startE through DONE like a stalled EX stage; operands are scrambled while busy
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eh, el;
    int          elat, stalls;
    bit          seen;
    model(op, a, b, eh, el, elat);
    @(posedge clk); #1;
    startE = 1'b1; opE = op; srcaE = a; srcbE = b;
    stalls = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hiwrite) begin seen = 1'b1; break; end
      if (stallE) stalls++;
      @(posedge clk); #1;
      srcaE = $urandom; srcbE = $urandom;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(elat));
    check({tag, "_hi"}, 64'(hiresult), 64'(eh));
    check({tag, "_lo"}, 64'(loresult), 64'(el));
    check({tag, "_lowrite"}, 64'(lowrite), 64'd1);
    check({tag, "_done_stall"}, 64'(stallE), 64'd0);
    @(posedge clk); #1;
    startE = 1'b0;
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_wr_after"}, 64'({hiwrite, lowrite}), 64'd0);
    check({tag, "_lo_hold"}, 64'(loresult), 64'(el));
  endtask

  initial begin
    int          nwr;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    resetn = 1'b0; startE = 1'b0; cancel = 1'b0;
    opE = 2'b00; srcaE = '0; srcbE = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stallE), 64'd0);
    check("rst_wr", 64'({hiwrite, lowrite}), 64'd0);
    check("rst_hi", 64'(hiresult), 64'd0);
    check("rst_lo", 64'(loresult), 64'd0);

    // start killed in the same cycle never leaves IDLE
    @(posedge clk); #1;
    startE = 1'b1; cancel = 1'b1; opE = 2'b10; srcaE = 32'd9; srcbE = 32'd3;
    @(negedge clk);
    check("startcancel_stall", 64'(stallE), 64'd0);
    @(posedge clk); #1;
    startE = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check("startcancel_busy", 64'(busy), 64'd0);

    run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, "mult_neg");
    run_op(2'b11, 32'd100, 32'd7, "divu_100_7");
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, "div_neg100_7");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_op(2'b11, 32'h1234_5678, 32'd0, "divu_by0");
    run_op(2'b10, 32'hDEAD_BEEF, 32'd0, "div_by0");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, "div_100_neg7");

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        3, 4:    rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op(rop, ra, rb, $sformatf("rnd%0d", i));
    end

    // cancel in the middle of a divide
    @(posedge clk); #1;
    startE = 1'b1; opE = 2'b10; srcaE = 32'd1000; srcbE = 32'd3;
    repeat (10) @(posedge clk);
    #1 cancel = 1'b1;
    @(negedge clk);
    check("cancel_stall", 64'(stallE), 64'd0);
    check("cancel_wr", 64'({hiwrite, lowrite}), 64'd0);
    @(posedge clk); #1;
    cancel = 1'b0; startE = 1'b0;
    @(negedge clk);
    check("cancel_idle", 64'(busy), 64'd0);
    nwr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hiwrite || lowrite) nwr++;
    end
    check("cancel_no_write", 64'(nwr), 64'd0);
    run_op(2'b01, 32'd5, 32'd6, "multu_5_6");

    // reset in the middle of a divide
    @(posedge clk); #1;
    startE = 1'b1; opE = 2'b11; srcaE = 32'd77777; srcbE = 32'd13;
    repeat (6) @(posedge clk);
    #1 resetn = 1'b0; startE = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_stall", 64'(stallE), 64'd0);
    check("midrst_wr", 64'({hiwrite, lowrite}), 64'd0);
    check("midrst_hi", 64'(hiresult), 64'd0);
    check("midrst_lo", 64'(loresult), 64'd0);
    run_op(2'b11, 32'd77777, 32'd13, "divu_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Sequencer for the multiply/divide unit that owns the HI/LO pair.
- Takes a MULT/MULTU/DIV/DIVU request from the EX stage and runs a fixed-latency multiply or a 32-step restoring divide.
- Holds the pipeline through the hazard stall network for the duration of the operation.
- Issues a single-cycle HI/LO write when the operation completes.

Parameters:
- WIDTH, 32, operand and result width.
- MUL_CYCLES, 2, cycles spent in MUL state (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous reset, active low.
- startE  in  1  valid MDU instruction present in EX this cycle.
- opE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srcaE  in  WIDTH  rs operand, already forwarded.
- srcbE  in  WIDTH  rt operand, already forwarded.
- cancel  in  1  exception/flush kill of the EX instruction.
- stallE  out  1  pipeline stall request, ORed into stallF/stallD/stallE by the hazard unit.
- busy  out  1  state != IDLE.
- hiwrite  out  1  HI write enable, one cycle.
- lowrite  out  1  LO write enable, one cycle.
- hiresult  out  WIDTH  value for HI.
- loresult  out  WIDTH  value for LO.

Behaviour:
- The clock port is clk and the reset port is resetn. There is one clock; reset is synchronous and active-low.
- Reset (resetn=0 at an edge): state=IDLE, counter=0, datapath registers=0. The registered outputs take these values: hiwrite=0, lowrite=0, hiresult=0, loresult=0, busy=0. Combinational stallE then evaluates to 0 while startE=0 or cancel=1.
- States:
  - IDLE: on startE & !cancel, latch operands and go to MUL (op 0x), DIV (op 1x), or DONE (divide by zero).
  - MUL: count MUL_CYCLES cycles, then go to DONE.
  - DIV: 32 iterations, one quotient bit per cycle, then go to DONE.
  - DONE: one cycle, then return to IDLE unconditionally.
- stallE (combinational) = !cancel & ((state==IDLE & startE) | state==MUL | state==DIV). It is low in DONE, so the MDU instruction leaves EX at the end of the DONE cycle. startE seen in DONE belongs to the same instruction and is ignored.
- hiwrite and lowrite are asserted together only in DONE. hiresult and loresult are registered and are stable in DONE.
- Latency, with the start cycle counted as N:
  - div: stallE high N..N+32 (33 cycles); DONE at N+33.
  - mult: stallE high N..N+MUL_CYCLES; DONE at N+MUL_CYCLES+1.
  - div-by-zero: stallE high at N only; DONE at N+1.
- Multiply: full 2*WIDTH product. HI = upper half, LO = lower half. MULT is signed; MULTU is unsigned.
- Divide:
  - Operate on magnitudes (|a|, |b| as unsigned WIDTH values) for DIV; DIVU uses raw operands.
  - Each step: shift remainder left, bring in the next dividend bit, subtract the divisor, and keep the result if it is non-negative.
  - Fix-up in the final step: quotient negated if sign(a)^sign(b) (DIV only); remainder negated if sign(a) (DIV only).
  - LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF signed gives LO=0x80000000, HI=0; this falls out of the magnitude path with no special case.
- Divide by zero (srcbE==0, either signedness): LO=0xFFFFFFFF, HI=srcaE. No iteration.
- cancel: highest priority. In any state, the next state is IDLE, the counter is cleared, and no HI/LO write occurs. stallE is forced low in the same cycle. cancel during DONE suppresses hiwrite/lowrite combinationally.
- Operands change while busy: ignored, because they are latched at start.
- Reset mid-operation: same effect as cancel, plus outputs are zeroed.

Decomposition:
- Shared package:
  - op encodings MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11.
  - state encodings S_IDLE, S_MUL, S_DIV, S_DONE.
  - constant DIV_STEPS=32.
- Sub-module div_step_core (combinational single iteration: {rem,quo} in → {rem,quo} out). mdu_seq instantiates it once and registers its result each DIV cycle. The multiply uses a registered product in mdu_seq.

Test Plan:
- MULT 0xFFFFFFFE * 0x00000003 -> stallE high 3 cycles; DONE: HI=0xFFFFFFFF, LO=0xFFFFFFFA, hiwrite=lowrite=1 for exactly 1 cycle.
- DIVU 100 / 7 -> stallE high 33 cycles; then LO=14, HI=2; busy low the cycle after DONE.
- DIV 0xFFFFFF9C (-100) / 7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2); DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x12345678 / 0 -> stallE high 1 cycle; next cycle LO=0xFFFFFFFF, HI=0x12345678 with write enables.
- Start DIV, assert cancel at iteration 10 -> stallE low that cycle; IDLE next cycle; no hiwrite/lowrite; a following MULTU 5*6 completes with LO=30, HI=0.
- Drive resetn=0 mid-DIV for 1 cycle -> next cycle IDLE, all outputs 0; startE held in DONE across two cycles does not retrigger.
